// File: rtl/ppu_pkg.sv
// Shared PPU types for the CGRAM palette path: word type, CPU register selects
// and the $213B byte-select helper.
package ppu_pkg;
  localparam int CGRAM_WORDS  = 256;
  localparam int CGRAM_ADDR_W = 8;
  localparam int CGRAM_DATA_W = 15;

  typedef logic [CGRAM_DATA_W-1:0] cgram_word_type;

  typedef enum logic [1:0] {
    CGADD   = 2'd0,
    CGDATA  = 2'd1,
    CGREAD  = 2'd2,
    CG_NONE = 2'd3
  } cpu_cgram_reg_type;

  // High byte carries open-bus bit 7 because the palette word is only 15 bits.
  function automatic logic [7:0] cgram_read_byte(input logic hi, input logic ob7,
                                                 input cgram_word_type w);
    return hi ? {ob7, w[14:8]} : w[7:0];
  endfunction
endpackage

// File: rtl/cgram_ram.sv
// 256x15 palette block RAM: one write port, synchronous read-before-write reads.
// Port B exists only when CGRAM_RENDER_QUIRK_EN is undefined.
module cgram_ram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 15
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr_a,
  output logic [DATA_W-1:0] o_rdata_a
`ifndef CGRAM_RENDER_QUIRK_EN
  ,
  input  logic [ADDR_W-1:0] i_raddr_b,
  output logic [DATA_W-1:0] o_rdata_b
`endif
);
  logic [DATA_W-1:0] r_mem [2**ADDR_W];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) o_rdata_a <= '0;
    else          o_rdata_a <= r_mem[i_raddr_a];
  end

`ifndef CGRAM_RENDER_QUIRK_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) o_rdata_b <= '0;
    else          o_rdata_b <= r_mem[i_raddr_b];
  end
`endif
endmodule

// File: rtl/cgram_controller.sv
// CGRAM controller: renderer palette port plus $2121/$2122/$213B byte-pair access.
// Optional CGRAM_RENDER_QUIRK_EN redirects CPU data accesses to cgram_addr during display.
module cgram_controller
  import ppu_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              render_active,
  input  logic [ADDR_W-1:0] cgram_addr,
  output logic [DATA_W-1:0] cgram_rdata,
  input  logic              cpu_wr,
  input  logic              cpu_rd,
  input  logic [1:0]        cpu_reg,
  input  logic [7:0]        cpu_wdata,
  input  logic [7:0]        open_bus,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_rdata_valid
);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  cpu_cgram_reg_type w_reg;
  logic              w_rd;
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [ADDR_W-1:0] w_raddr_a;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_cpu_word;
  logic              w_unused;

  logic [ADDR_W-1:0] r_word_addr;
  logic              r_flag;
  logic [7:0]        r_latch;
  logic              r_rd_vld_p0;
  logic              r_rd_hi_p0;
  logic              r_ob7_p0;
  logic [7:0]        r_cpu_rdata_p1;
  logic              r_rd_vld_p1;

  assign w_reg   = cpu_cgram_reg_type'(cpu_reg);
  assign w_rd    = cpu_rd && !cpu_wr && (w_reg == CGREAD);
  assign w_we    = cpu_wr && (w_reg == CGDATA) && r_flag;
  assign w_wdata = {cpu_wdata[6:0], r_latch};

`ifdef CGRAM_RENDER_QUIRK_EN
  // Single read port: outside display a $213B read borrows it for one cycle.
  assign w_waddr    = render_active ? cgram_addr : r_word_addr;
  assign w_raddr_a  = (w_rd && !render_active) ? r_word_addr : cgram_addr;
  assign w_cpu_word = cgram_rdata;
  assign w_unused   = ^open_bus[6:0];

  cgram_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
    .i_clk     (clk),
    .i_rst_n   (reset_n),
    .i_we      (w_we),
    .i_waddr   (w_waddr),
    .i_wdata   (w_wdata),
    .i_raddr_a (w_raddr_a),
    .o_rdata_a (cgram_rdata)
  );
`else
  assign w_waddr   = r_word_addr;
  assign w_raddr_a = cgram_addr;
  assign w_unused  = ^{open_bus[6:0], render_active};

  cgram_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
    .i_clk     (clk),
    .i_rst_n   (reset_n),
    .i_we      (w_we),
    .i_waddr   (w_waddr),
    .i_wdata   (w_wdata),
    .i_raddr_a (w_raddr_a),
    .o_rdata_a (cgram_rdata),
    .i_raddr_b (r_word_addr),
    .o_rdata_b (w_cpu_word)
  );
`endif

  // The byte flag is shared between $2122 writes and $213B reads.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_word_addr <= '0;
      r_flag      <= 1'b0;
      r_latch     <= '0;
    end else if (cpu_wr) begin
      case (w_reg)
        CGADD: begin
          r_word_addr <= ADDR_W'(cpu_wdata);
          r_flag      <= 1'b0;
        end
        CGDATA: begin
          if (!r_flag) begin
            r_latch <= cpu_wdata;
            r_flag  <= 1'b1;
          end else begin
            r_flag      <= 1'b0;
            r_word_addr <= r_word_addr + ADDR_ONE;
          end
        end
        default: ;
      endcase
    end else if (w_rd) begin
      r_flag <= ~r_flag;
      if (r_flag) r_word_addr <= r_word_addr + ADDR_ONE;
    end
  end

  // p0: byte select captured with the RAM read launched at the same edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_vld_p0 <= 1'b0;
      r_rd_hi_p0  <= 1'b0;
      r_ob7_p0    <= 1'b0;
    end else begin
      r_rd_vld_p0 <= w_rd;
      r_rd_hi_p0  <= r_flag;
      r_ob7_p0    <= open_bus[7];
    end
  end

  // p1: byte steered out of the RAM word
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cpu_rdata_p1 <= '0;
      r_rd_vld_p1    <= 1'b0;
    end else begin
      r_rd_vld_p1 <= r_rd_vld_p0;
      if (r_rd_vld_p0) r_cpu_rdata_p1 <= cgram_read_byte(r_rd_hi_p0, r_ob7_p0, w_cpu_word);
    end
  end

  assign cpu_rdata       = r_cpu_rdata_p1;
  assign cpu_rdata_valid = r_rd_vld_p1;
endmodule
